// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge
// Load/store-unit master bridge. Turns one CPU memory request at a time into an
// AXI-lite-style transaction on the AR/R (loads) or AW/W/B (stores) channels,
// then presents a single response (sized/extended load data + error flag).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_*                      CPU request (valid/ready, wen, addr, size, signed, wdata)
//   resp_*                     CPU response (valid/ready, rdata, err)
//   arAddr/arWidth/arValid/arReady, rData/rValid/rReady      read channels
//   awAddr/awPort/awValid/awReady, wData/wStrb/wValid/wReady write channels
//   bResp/bValid/bReady                                       write response
//
// Parameters:
//   TIMEOUT  cycles allowed outside IDLE/RESP before the transaction is
//            aborted with resp_err=1; 0 disables the watchdog.
//
// Optional build macro:
//   LSU_BRIDGE_MISALIGN_CHECK_EN  reject misaligned half/word requests without
//                                 touching the bus (resp_err=1, resp_rdata=0).
module lsu_axi_bridge #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] arAddr,
  output logic [31:0] arWidth,
  output logic        arValid,
  input  logic        arReady,
  input  logic [31:0] rData,
  input  logic        rValid,
  output logic        rReady,
  output logic [31:0] awAddr,
  output logic [1:0]  awPort,
  output logic        awValid,
  input  logic        awReady,
  output logic [31:0] wData,
  output logic [3:0]  wStrb,
  output logic        wValid,
  input  logic        wReady,
  input  logic [1:0]  bResp,
  input  logic        bValid,
  output logic        bReady
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT > 0);
  localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  // Byte count presented on arWidth; size 3 is treated as a word.
  function automatic logic [31:0] size_to_width(input logic [1:0] sz);
    case (sz)
      2'd0:    size_to_width = 32'd1;
      2'd1:    size_to_width = 32'd2;
      default: size_to_width = 32'd4;
    endcase
  endfunction

  // Byte-lane strobe for LSB-aligned store data.
  function automatic logic [3:0] size_to_strb(input logic [1:0] sz);
    case (sz)
      2'd0:    size_to_strb = 4'b0001;
      2'd1:    size_to_strb = 4'b0011;
      default: size_to_strb = 4'b1111;
    endcase
  endfunction

  // Size and sign/zero-extend LSB-aligned load data.
  function automatic logic [31:0] extend_load(input logic [31:0] d,
                                              input logic [1:0]  sz,
                                              input logic        sgn);
    case (sz)
      2'd0:    extend_load = {{24{sgn & d[7]}}, d[7:0]};
      2'd1:    extend_load = {{16{sgn & d[15]}}, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

`ifdef LSU_BRIDGE_MISALIGN_CHECK_EN
  // Half at an odd address, or word (incl. size 3) not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction
`endif

  state_t      state_r, state_s;
  logic [31:0] addr_r;
  logic [31:0] width_r;
  logic [3:0]  strb_r;
  logic [31:0] wdata_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        aw_done_r, aw_done_s;
  logic        w_done_r, w_done_s;
  logic [31:0] wd_r, wd_s;
  logic [31:0] rdata_r, rdata_s;
  logic        err_r, err_s;
  logic        accept_s;
  logic        bus_state_s;
  logic        timeout_s;
  logic        mis_s;

  assign accept_s    = (state_r == S_IDLE) && req_valid;
  assign bus_state_s = (state_r == S_AR) || (state_r == S_R) ||
                       (state_r == S_WR) || (state_r == S_B);
  assign timeout_s   = WD_EN && bus_state_s && (wd_r == WD_LAST);

  // Misalignment decode for the incoming request (constant 0 when the check is off).
  always_comb begin
`ifdef LSU_BRIDGE_MISALIGN_CHECK_EN
    mis_s = is_misaligned(req_addr[1:0], req_size);
`else
    mis_s = 1'b0;
`endif
  end

  // Next-state, watchdog, handshake-tracking and response-capture logic.
  always_comb begin
    state_s   = state_r;
    rdata_s   = rdata_r;
    err_s     = err_r;
    aw_done_s = aw_done_r;
    w_done_s  = w_done_r;
    if (WD_EN && bus_state_s) begin
      wd_s = wd_r + 32'd1;
    end else begin
      wd_s = wd_r;
    end

    if (timeout_s) begin
      // Leaving the bus states drops every valid/ready in the same edge.
      state_s = S_RESP;
      rdata_s = 32'd0;
      err_s   = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
          wd_s      = 32'd0;
          if (req_valid) begin
            if (mis_s) begin
              state_s = S_RESP;
              rdata_s = 32'd0;
              err_s   = 1'b1;
            end else if (req_wen) begin
              state_s = S_WR;
            end else begin
              state_s = S_AR;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_AR: begin
          if (arReady) begin
            state_s = S_R;
          end else begin
            state_s = S_AR;
          end
        end
        S_R: begin
          if (rValid) begin
            state_s = S_RESP;
            rdata_s = extend_load(rData, size_r, signed_r);
            err_s   = 1'b0;
          end else begin
            state_s = S_R;
          end
        end
        S_WR: begin
          // Sticky flags: each channel's valid stays up only until its own handshake.
          aw_done_s = aw_done_r | awReady;
          w_done_s  = w_done_r | wReady;
          if (aw_done_s && w_done_s) begin
            state_s = S_B;
          end else begin
            state_s = S_WR;
          end
        end
        S_B: begin
          if (bValid) begin
            state_s = S_RESP;
            rdata_s = 32'd0;
            err_s   = (bResp != 2'b00);
          end else begin
            state_s = S_B;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_RESP;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State, tracking flags, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      wd_r      <= 32'd0;
      rdata_r   <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      aw_done_r <= aw_done_s;
      w_done_r  <= w_done_s;
      wd_r      <= wd_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
    end
  end

  // Request capture: address/data/size held from acceptance to the next acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r   <= 32'd0;
      width_r  <= 32'd0;
      strb_r   <= 4'd0;
      wdata_r  <= 32'd0;
      size_r   <= 2'd0;
      signed_r <= 1'b0;
    end else if (accept_s) begin
      addr_r   <= req_addr;
      width_r  <= size_to_width(req_size);
      strb_r   <= size_to_strb(req_size);
      wdata_r  <= req_wdata;
      size_r   <= req_size;
      signed_r <= req_signed;
    end else begin
      addr_r   <= addr_r;
      width_r  <= width_r;
      strb_r   <= strb_r;
      wdata_r  <= wdata_r;
      size_r   <= size_r;
      signed_r <= signed_r;
    end
  end

  // Handshake outputs decode only from registered state; no bus-input to bus-output path.
  assign req_ready  = (state_r == S_IDLE);
  assign resp_valid = (state_r == S_RESP);
  assign resp_rdata = rdata_r;
  assign resp_err   = err_r;
  assign arValid    = (state_r == S_AR);
  assign rReady     = (state_r == S_R);
  assign awValid    = (state_r == S_WR) && !aw_done_r;
  assign wValid     = (state_r == S_WR) && !w_done_r;
  assign bReady     = (state_r == S_B);
  assign arAddr     = addr_r;
  assign awAddr     = addr_r;
  assign arWidth    = width_r;
  assign wData      = wdata_r;
  assign wStrb      = strb_r;
  assign awPort     = 2'b00;

endmodule
